// File: rtl/qed_inst_pkg.sv
// Shared encodings for the QED instruction constraint: RV32I opcode fields, instruction
// classes, run modes, sequencer states and the mode permission table.
package qed_inst_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_NOP    = 7'b1111111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SR      = 3'b101;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [3:0] {
      CLS_NOP, CLS_R, CLS_I, CLS_LUI, CLS_LOAD, CLS_STORE, CLS_BRANCH,
      CLS_JAL, CLS_JALR, CLS_AUIPC, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
   } inst_class_e;

   typedef enum logic [1:0] {MODE_NOP_ONLY, MODE_ALU, MODE_ALU_MEM, MODE_FULL} qed_mode_e;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} qed_state_e;

   // Each mode is a strict superset of the one below it.
   function automatic logic mode_permits(input qed_mode_e m, input inst_class_e c);
      logic alu;
      logic mem;
      alu = (c == CLS_R) || (c == CLS_I) || (c == CLS_LUI);
      mem = (c == CLS_LOAD) || (c == CLS_STORE);
      case (m)
         MODE_ALU:     return alu;
         MODE_ALU_MEM: return alu || mem;
         MODE_FULL:    return c != CLS_ILLEGAL;
         default:      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_inst_classifier.sv
// Combinational RV32I classifier; any word that breaks the QED register/offset
// restrictions of its format is reported as CLS_ILLEGAL.
module rv32i_inst_classifier
   import qed_inst_pkg::*;
#(
   parameter int unsigned REG_LIMIT     = 16,
   parameter int unsigned MEM_OFF_LIMIT = 64
) (
   input  logic [31:0]  instruction,
   output inst_class_e  inst_class
);

   logic [6:0]  w_opc;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic        w_rd_ok, w_rs1_ok, w_rs2_ok;
   logic [11:0] w_ld_off, w_st_off;
   logic        w_mem_base_ok;

   assign w_opc    = instruction[6:0];
   assign w_rd     = instruction[11:7];
   assign w_f3     = instruction[14:12];
   assign w_rs1    = instruction[19:15];
   assign w_rs2    = instruction[24:20];
   assign w_f7     = instruction[31:25];
   assign w_rd_ok  = {27'd0, w_rd} < REG_LIMIT;
   assign w_rs1_ok = {27'd0, w_rs1} < REG_LIMIT;
   assign w_rs2_ok = {27'd0, w_rs2} < REG_LIMIT;
   assign w_ld_off = instruction[31:20];
   assign w_st_off = {instruction[31:25], instruction[11:7]};
   // Memory ops address only a small positive window off x0.
   assign w_mem_base_ok = (w_rs1 == 5'd0) && (instruction[31:30] == 2'b00);

   always_comb begin
      inst_class = CLS_ILLEGAL;
      case (w_opc)
         OPC_NOP: inst_class = CLS_NOP;
         OPC_OP: begin
            if (w_rd_ok && w_rs1_ok && w_rs2_ok &&
                ((w_f7 == F7_BASE) ||
                 ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SR)))))
               inst_class = CLS_R;
         end
         OPC_OP_IMM: begin
            if (w_rd_ok && w_rs1_ok &&
                ((w_f3 == F3_SLL) ? (w_f7 == F7_BASE) :
                 (w_f3 == F3_SR)  ? ((w_f7 == F7_BASE) || (w_f7 == F7_ALT)) : 1'b1))
               inst_class = CLS_I;
         end
         OPC_LUI: if (w_rd_ok) inst_class = CLS_LUI;
         OPC_LOAD: begin
            if (w_mem_base_ok && w_rd_ok && ({20'd0, w_ld_off} < MEM_OFF_LIMIT) &&
                (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111))
               inst_class = CLS_LOAD;
         end
         OPC_STORE: begin
            if (w_mem_base_ok && w_rs2_ok && ({20'd0, w_st_off} < MEM_OFF_LIMIT) &&
                (w_f3[2] == 1'b0) && (w_f3 != 3'b011))
               inst_class = CLS_STORE;
         end
         OPC_BRANCH: begin
            if (w_rs1_ok && w_rs2_ok && (w_f3 != 3'b010) && (w_f3 != 3'b011))
               inst_class = CLS_BRANCH;
         end
         // PC-relative results would differ between the original and duplicate halves.
         OPC_JAL:   if (w_rd == 5'd0) inst_class = CLS_JAL;
         OPC_JALR:  if ((w_rd == 5'd0) && (w_f3 == 3'b000) && w_rs1_ok) inst_class = CLS_JALR;
         OPC_AUIPC: if (w_rd == 5'd0) inst_class = CLS_AUIPC;
         OPC_FENCE: if ((w_f3 == 3'b000) && w_rd_ok && w_rs1_ok) inst_class = CLS_FENCE;
         OPC_SYSTEM: begin
            if ((instruction == INST_ECALL) || (instruction == INST_EBREAK))
               inst_class = CLS_SYSTEM;
         end
         default: inst_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/qed_inst_constraint_seq.sv
// Stateful QED instruction constraint: latches a run mode, bounds the number of
// non-NOP instructions per run, drains with NOPs, and records any illegal fetch.
module qed_inst_constraint_seq
   import qed_inst_pkg::*;
#(
   parameter int unsigned REG_LIMIT     = 16,
   parameter int unsigned MEM_OFF_LIMIT = 64,
   parameter int unsigned MAX_INSTS     = 8,
   parameter int unsigned DRAIN_CYCLES  = 4,
   parameter bit          ENABLE_ASSUME = 1'b1,
   localparam int unsigned CntW         = $clog2(MAX_INSTS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instruction,
   input  logic             inst_valid,
   input  logic             start,
   input  logic [1:0]       mode,
   output logic             allowed,
   output inst_class_e      inst_class,
   output logic [1:0]       state,
   output logic [CntW-1:0]  issued_cnt,
   output logic             done,
   output logic             violation
);

   localparam int unsigned     DrainW    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
   localparam logic [DrainW-1:0] DrainLast = DrainW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
   localparam logic [CntW-1:0] CntLast   = CntW'(MAX_INSTS - 1);
   localparam logic [CntW-1:0] CntMax    = CntW'(MAX_INSTS);

   qed_state_e        r_state;
   qed_mode_e         r_mode;
   logic [CntW-1:0]   r_issued_cnt;
   logic [DrainW-1:0] r_drain_cnt;
   logic              r_done;
   logic              r_violation;
   logic              w_is_nop;
   logic              w_allowed;
   logic              w_accept;

   rv32i_inst_classifier #(
      .REG_LIMIT     (REG_LIMIT),
      .MEM_OFF_LIMIT (MEM_OFF_LIMIT)
   ) u_classifier (
      .instruction (instruction),
      .inst_class  (inst_class)
   );

   assign w_is_nop  = (inst_class == CLS_NOP);
   assign w_allowed = w_is_nop || ((r_state == ST_ISSUE) && mode_permits(r_mode, inst_class));
   assign w_accept  = inst_valid && w_allowed && !w_is_nop && (r_state == ST_ISSUE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_mode       <= MODE_NOP_ONLY;
         r_issued_cnt <= '0;
         r_drain_cnt  <= '0;
         r_done       <= 1'b0;
         r_violation  <= 1'b0;
      end else begin
         if (inst_valid && !w_allowed) r_violation <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mode       <= qed_mode_e'(mode);
                  r_issued_cnt <= '0;
                  r_state      <= ST_ISSUE;
               end
            end
            // With MODE_NOP_ONLY nothing is ever accepted, so the run parks here.
            ST_ISSUE: begin
               if (w_accept) begin
                  if (r_issued_cnt < CntMax) r_issued_cnt <= r_issued_cnt + CntW'(1);
                  if (r_issued_cnt == CntLast) begin
                     r_drain_cnt <= '0;
                     if (DRAIN_CYCLES == 0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_DRAIN;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               r_drain_cnt <= r_drain_cnt + DrainW'(1);
               if (r_drain_cnt == DrainLast) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign allowed    = w_allowed;
   assign state      = r_state;
   assign issued_cnt = r_issued_cnt;
   assign done       = r_done;
   assign violation  = r_violation;

   if (ENABLE_ASSUME) begin : g_assume
      a_inst_allowed: assume property (@(posedge clk) disable iff (rst) inst_valid |-> allowed);
   end

endmodule

// File: tb/tb_qed_inst_constraint_seq.sv
// Scoreboard bench for qed_inst_constraint_seq: per-cycle expectations are queued as
// stimulus is driven and compared when the combinational and registered outputs settle.
module tb_qed_inst_constraint_seq;
   import qed_inst_pkg::*;

   localparam logic [31:0] NOP     = 32'h0000_007F;
   localparam logic [31:0] ADD     = 32'h0031_00B3;
   localparam logic [31:0] SUB     = 32'h4031_00B3;
   localparam logic [31:0] ADD_X16 = 32'h0010_8833;
   localparam logic [31:0] LW0     = 32'h0000_2083;
   localparam logic [31:0] LW4     = 32'h0040_2083;
   localparam logic [31:0] LW64    = 32'h0400_2083;
   localparam logic [31:0] LW_X2   = 32'h0001_2083;
   localparam logic [31:0] SW4     = 32'h0010_2223;
   localparam logic [31:0] SRAI    = 32'h4031_5093;
   localparam logic [31:0] SLLI_BAD= 32'h4031_1093;
   localparam logic [31:0] JAL_X0  = 32'h0080_006F;
   localparam logic [31:0] JAL_X1  = 32'h0080_00EF;
   localparam logic [31:0] ECALL   = 32'h0000_0073;
   localparam logic [31:0] AUIPC0  = 32'h0000_1017;
   localparam logic [31:0] ZERO    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic        inst_valid, start;
   logic [1:0]  mode;
   logic        allowed, done, violation;
   inst_class_e inst_class;
   logic [1:0]  state;
   logic [3:0]  issued_cnt;
   logic        allowed0, done0, violation0;
   inst_class_e inst_class0;
   logic [1:0]  state0;
   logic [3:0]  issued_cnt0;

   always #5 clk = ~clk;

   qed_inst_constraint_seq #(.ENABLE_ASSUME(1'b0)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
      .start(start), .mode(mode), .allowed(allowed), .inst_class(inst_class),
      .state(state), .issued_cnt(issued_cnt), .done(done), .violation(violation)
   );

   qed_inst_constraint_seq #(.DRAIN_CYCLES(0), .ENABLE_ASSUME(1'b0)) dut0 (
      .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
      .start(start), .mode(mode), .allowed(allowed0), .inst_class(inst_class0),
      .state(state0), .issued_cnt(issued_cnt0), .done(done0), .violation(violation0)
   );

   typedef struct {
      string      tag;
      logic       ea;
      logic [3:0] ec;
      logic [1:0] es;
      logic [3:0] en;
      logic       ev;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   // Drive one cycle; ea/ec are this cycle's combinational outputs, es/en/ev the
   // registered state after the following clock edge.
   task automatic cyc(input logic [31:0] ins, input logic v, input logic st,
                      input logic [1:0] md, input logic rs, input string tag,
                      input logic ea, input logic [3:0] ec, input logic [1:0] es,
                      input logic [3:0] en, input logic ev);
      exp_t e;
      instruction = ins;
      inst_valid  = v;
      start       = st;
      mode        = md;
      rst         = rs;
      e.tag = tag; e.ea = ea; e.ec = ec; e.es = es; e.en = en; e.ev = ev;
      sb.push_back(e);
      @(negedge clk);
      check({sb[0].tag, ".allowed"}, allowed, sb[0].ea);
      check({sb[0].tag, ".class"}, inst_class, sb[0].ec);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".state"}, state, e.es);
      check({e.tag, ".cnt"}, issued_cnt, e.en);
      check({e.tag, ".viol"}, violation, e.ev);
      check({e.tag, ".done"}, done, e.es == ST_DONE);
   endtask

   initial begin
      rst = 1'b1; instruction = NOP; inst_valid = 1'b0; start = 1'b0; mode = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.state", state, ST_IDLE);
      check("rst.cnt", issued_cnt, 0);
      check("rst.viol", violation, 0);
      check("rst.done", done, 0);

      // IDLE admits only NOPs; invalid cycles never violate
      cyc(NOP, 1, 0, 2'd0, 0, "t1_nop", 1, CLS_NOP, ST_IDLE, 0, 0);
      cyc(ADD, 0, 0, 2'd1, 0, "t1_add_inv", 0, CLS_R, ST_IDLE, 0, 0);

      // ALU run to completion; mode input changes after start are ignored
      cyc(NOP, 0, 1, 2'd1, 0, "t2_start", 1, CLS_NOP, ST_ISSUE, 0, 0);
      cyc(ADD, 0, 0, 2'd0, 0, "t2_add_inv", 1, CLS_R, ST_ISSUE, 0, 0);
      for (int i = 0; i < 8; i++)
         cyc(ADD, 1, 0, 2'd0, 0, "t2_add", 1, CLS_R, (i == 7) ? ST_DRAIN : ST_ISSUE,
             4'(i + 1), 0);
      check("t5_dc0.state", state0, ST_DONE);
      check("t5_dc0.done", done0, 1);
      for (int j = 0; j < 4; j++)
         cyc(NOP, 1, 0, 2'd0, 0, "t2_drain", 1, CLS_NOP, (j == 3) ? ST_DONE : ST_DRAIN, 8, 0);
      cyc(NOP, 1, 1, 2'd2, 0, "t6_done_start", 1, CLS_NOP, ST_DONE, 8, 0);
      cyc(ADD, 0, 0, 2'd0, 0, "t2_done_add", 0, CLS_R, ST_DONE, 8, 0);
      cyc(NOP, 0, 0, 2'd0, 1, "t2_rst", 1, CLS_NOP, ST_IDLE, 0, 0);

      // Load rejected under ALU mode; an accept in the reset cycle is not counted
      cyc(NOP, 0, 1, 2'd1, 0, "t3_start", 1, CLS_NOP, ST_ISSUE, 0, 0);
      cyc(ADD, 1, 0, 2'd0, 0, "t3_add", 1, CLS_R, ST_ISSUE, 1, 0);
      cyc(LW0, 1, 0, 2'd0, 0, "t3_lw", 0, CLS_LOAD, ST_ISSUE, 1, 1);
      cyc(ADD, 1, 0, 2'd0, 1, "t3_rst_acc", 1, CLS_R, ST_IDLE, 0, 0);

      // ALU_MEM: offset and base limits, register limit, shift funct7 checks
      cyc(NOP, 0, 1, 2'd2, 0, "t4_start", 1, CLS_NOP, ST_ISSUE, 0, 0);
      cyc(LW4, 1, 0, 2'd0, 0, "t4_lw4", 1, CLS_LOAD, ST_ISSUE, 1, 0);
      cyc(LW64, 0, 0, 2'd0, 0, "t4_lw64", 0, CLS_ILLEGAL, ST_ISSUE, 1, 0);
      cyc(LW_X2, 0, 0, 2'd0, 0, "t4_lw_x2", 0, CLS_ILLEGAL, ST_ISSUE, 1, 0);
      cyc(ADD_X16, 1, 0, 2'd0, 0, "t4_add_x16", 0, CLS_ILLEGAL, ST_ISSUE, 1, 1);
      cyc(SW4, 1, 0, 2'd0, 0, "t4_sw4", 1, CLS_STORE, ST_ISSUE, 2, 1);
      cyc(JAL_X0, 0, 0, 2'd0, 0, "t4_jal", 0, CLS_JAL, ST_ISSUE, 2, 1);
      cyc(SUB, 1, 0, 2'd0, 0, "t4_sub", 1, CLS_R, ST_ISSUE, 3, 1);
      cyc(SRAI, 1, 0, 2'd0, 0, "t4_srai", 1, CLS_I, ST_ISSUE, 4, 1);
      cyc(SLLI_BAD, 0, 0, 2'd0, 0, "t4_slli_bad", 0, CLS_ILLEGAL, ST_ISSUE, 4, 1);
      cyc(NOP, 0, 0, 2'd0, 1, "t4_rst", 1, CLS_NOP, ST_IDLE, 0, 0);

      // FULL: control flow with rd==0 only
      cyc(NOP, 0, 1, 2'd3, 0, "t5_start", 1, CLS_NOP, ST_ISSUE, 0, 0);
      cyc(JAL_X0, 1, 0, 2'd0, 0, "t5_jal_x0", 1, CLS_JAL, ST_ISSUE, 1, 0);
      cyc(JAL_X1, 1, 0, 2'd0, 0, "t5_jal_x1", 0, CLS_ILLEGAL, ST_ISSUE, 1, 1);
      cyc(ECALL, 1, 0, 2'd0, 0, "t5_ecall", 1, CLS_SYSTEM, ST_ISSUE, 2, 1);
      cyc(AUIPC0, 1, 0, 2'd0, 0, "t5_auipc", 1, CLS_AUIPC, ST_ISSUE, 3, 1);
      cyc(ZERO, 0, 0, 2'd0, 0, "t5_zero", 0, CLS_ILLEGAL, ST_ISSUE, 3, 1);
      for (int i = 0; i < 5; i++)
         cyc(ADD, 1, 0, 2'd0, 0, "t5_add", 1, CLS_R, (i == 4) ? ST_DRAIN : ST_ISSUE,
             4'(i + 4), 1);
      cyc(NOP, 0, 0, 2'd0, 1, "t5_rst", 1, CLS_NOP, ST_IDLE, 0, 0);

      // Non-NOP in DRAIN violates; reset in DRAIN with start held returns to IDLE
      cyc(NOP, 0, 1, 2'd1, 0, "t6_start", 1, CLS_NOP, ST_ISSUE, 0, 0);
      for (int i = 0; i < 8; i++)
         cyc(ADD, 1, 0, 2'd0, 0, "t6_add", 1, CLS_R, (i == 7) ? ST_DRAIN : ST_ISSUE,
             4'(i + 1), 0);
      cyc(ADD, 1, 1, 2'd1, 0, "t6_drain_add", 0, CLS_R, ST_DRAIN, 8, 1);
      cyc(ADD, 1, 1, 2'd1, 1, "t6_rst_drain", 0, CLS_R, ST_IDLE, 0, 0);
      cyc(NOP, 1, 0, 2'd0, 0, "t6_idle", 1, CLS_NOP, ST_IDLE, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
